// File: rtl/nn_pkg.sv
// Shared constants and helpers for the small NN datapath blocks.
// Latency: n/a (package).
// Backpressure: n/a (package).
package nn_pkg;

  // Activation (next-layer operand) width and accumulator (dot-product) width.
  localparam int ACT_W = 8;
  localparam int ACC_W = 16;
  // Width of a biased, rounded accumulator sum: two guard bits so y+b+rnd never wraps.
  localparam int SUM_W = ACC_W + 2;

  typedef struct packed {
    logic signed [ACT_W-1:0] val;  // clamped value, low ACT_W bits
    logic                    sat;  // 1 when the clamp changed the value
  } sat_res_t;

  // Clamp a signed sum into a signed 'width'-bit range and report whether it clipped.
  function automatic sat_res_t sat_signed(input logic signed [SUM_W-1:0] value,
                                          input int                      width);
    sat_res_t                r;
    logic signed [SUM_W-1:0] one;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    one   = {{(SUM_W-1){1'b0}}, 1'b1};
    hi    = (one <<< (width - 1)) - one;
    lo    = ~hi;
    r.val = value[ACT_W-1:0];
    r.sat = 1'b0;
    if (value > hi) begin
      r.val = hi[ACT_W-1:0];
      r.sat = 1'b1;
    end else if (value < lo) begin
      r.val = lo[ACT_W-1:0];
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One requantization lane: arithmetic shift, optional ReLU, clamp to signed OUT_W.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage owns the handshake.
module requant_lane
  import nn_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = ACT_W,
  parameter int SH_W  = 4
) (
  input  logic signed [IN_W+1:0]  sum,
  input  logic        [SH_W-1:0]  shift,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] z,
  output logic                    sat
);

  logic signed [IN_W+1:0] shifted;
  sat_res_t               res;

  // Shift, zero negatives when ReLU is on (not a saturation event), then clamp.
  always_comb begin
    shifted = sum >>> shift;
    if (relu_en && shifted[IN_W+1]) begin
      shifted = '0;
    end
    res = sat_signed(shifted, OUT_W);
    z   = res.val;
    sat = res.sat;
  end

endmodule

// File: rtl/relu_requant3.sv
// Three-lane bias + rounding shift + ReLU + int8 saturation, with a saturation counter.
// Latency: 2 cycles accept-to-out_valid; 1 vector/cycle with out_ready held high.
// Backpressure: valid/ready both sides; in_ready is combinational from out_ready, stalls hold.
module relu_requant3
  import nn_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = ACT_W,
  parameter int SH_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  y1,
  input  logic signed [IN_W-1:0]  y2,
  input  logic signed [IN_W-1:0]  y3,
  input  logic signed [IN_W-1:0]  b1,
  input  logic signed [IN_W-1:0]  b2,
  input  logic signed [IN_W-1:0]  b3,
  input  logic        [SH_W-1:0]  shift,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] z1,
  output logic signed [OUT_W-1:0] z2,
  output logic signed [OUT_W-1:0] z3,
  output logic        [CNT_W-1:0] sat_count,
  input  logic                    clr_count
);

  localparam int S_W = IN_W + 2;
  localparam logic signed [S_W-1:0] ONE = {{(S_W-1){1'b0}}, 1'b1};

  logic                    s1_valid_q, s1_valid_d;
  logic signed [S_W-1:0]   s1_sum_q [3];
  logic signed [S_W-1:0]   s1_sum_d [3];
  logic        [SH_W-1:0]  s1_shift_q, s1_shift_d;
  logic                    s1_relu_q, s1_relu_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [OUT_W-1:0] z_q [3];
  logic signed [OUT_W-1:0] z_d [3];
  logic        [CNT_W-1:0] sat_count_q, sat_count_d;

  logic                    s1_adv, s2_adv;
  logic signed [IN_W-1:0]  y_in [3];
  logic signed [IN_W-1:0]  b_in [3];
  logic signed [S_W-1:0]   rnd;
  logic signed [OUT_W-1:0] lane_z [3];
  logic        [2:0]       lane_sat;
  logic        [1:0]       sat_inc;
  logic        [CNT_W:0]   cnt_sum;

  // Handshake: a stage advances when it is empty or the stage after it advances.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  // Stage 1: sign-extend, add bias and the round-half-up constant at S_W bits.
  always_comb begin
    y_in[0] = y1; y_in[1] = y2; y_in[2] = y3;
    b_in[0] = b1; b_in[1] = b2; b_in[2] = b3;
    rnd = '0;
    if (shift != '0) begin
      rnd = ONE <<< (shift - SH_W'(1));
    end
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_shift_d = s1_shift_q;
    s1_relu_d  = s1_relu_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          s1_sum_d[i] = $signed({{2{y_in[i][IN_W-1]}}, y_in[i]})
                      + $signed({{2{b_in[i][IN_W-1]}}, b_in[i]}) + rnd;
        end
        s1_shift_d = shift;
        s1_relu_d  = relu_en;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_lane
    requant_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SH_W  (SH_W)
    ) u_lane (
      .sum     (s1_sum_q[g]),
      .shift   (s1_shift_q),
      .relu_en (s1_relu_q),
      .z       (lane_z[g]),
      .sat     (lane_sat[g])
    );
  end

  // Stage 2 and counter: load lane results; count clamps; clear beats increment.
  always_comb begin
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        z_d = lane_z;
      end
    end
    sat_inc     = {1'b0, lane_sat[0]} + {1'b0, lane_sat[1]} + {1'b0, lane_sat[2]};
    cnt_sum     = {1'b0, sat_count_q} + {{(CNT_W-1){1'b0}}, sat_inc};
    sat_count_d = sat_count_q;
    if (clr_count) begin
      sat_count_d = '0;
    end else if (s2_adv && s1_valid_q) begin
      sat_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  // Pipeline and counter state; reset drops any in-flight vectors at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '{default: '0};
      s1_shift_q  <= '0;
      s1_relu_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      z_q         <= '{default: '0};
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_shift_q  <= s1_shift_d;
      s1_relu_q   <= s1_relu_d;
      s2_valid_q  <= s2_valid_d;
      z_q         <= z_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign z1        = z_q[0];
  assign z2        = z_q[1];
  assign z3        = z_q[2];
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_relu_requant3.sv
// Self-checking bench for relu_requant3: directed steps plus a randomized stream.
// Expected outputs come from an arithmetic reference model and an in-order queue.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_relu_requant3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] y1, y2, y3, b1, b2, b3;
  logic        [3:0]  shift;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  z1, z2, z3;
  logic        [15:0] sat_count;
  logic               clr_count;

  typedef struct {
    int z[3];
    int nsat;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   fail_cnt = 0;
  int   exp_cnt = 0;
  int   out_seen = 0;

  always #5 clk = ~clk;

  relu_requant3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .b1        (b1),
    .b2        (b2),
    .b3        (b3),
    .shift     (shift),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z1        (z1),
    .z2        (z2),
    .z3        (z3),
    .sat_count (sat_count),
    .clr_count (clr_count)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: value = floor((y + b + half-LSB) / 2^shift), ReLU, clamp to int8.
  function automatic exp_t model(input int ya, input int yb, input int yc,
                                 input int ba, input int bb, input int bc,
                                 input int sh, input bit relu);
    exp_t e;
    int   ys[3];
    int   bs[3];
    ys[0] = ya; ys[1] = yb; ys[2] = yc;
    bs[0] = ba; bs[1] = bb; bs[2] = bc;
    e.nsat = 0;
    for (int i = 0; i < 3; i++) begin
      int s;
      int t;
      s = ys[i] + bs[i] + ((sh > 0) ? (1 << (sh - 1)) : 0);
      t = int'($floor(real'(s) / real'(1 << sh)));
      if (relu && t < 0) t = 0;
      if (t > 127) begin
        t = 127;
        e.nsat++;
      end else if (t < -128) begin
        t = -128;
        e.nsat++;
      end
      e.z[i] = t;
    end
    return e;
  endfunction

  task automatic set_vec(input int ya, input int yb, input int yc, input int ba,
                         input int bb, input int bc, input int sh, input bit relu);
    y1 = 16'(ya); y2 = 16'(yb); y3 = 16'(yc);
    b1 = 16'(ba); b2 = 16'(bb); b3 = 16'(bc);
    shift = 4'(sh);
    relu_en = relu;
  endtask

  // One clock: check the output against the queue head, record an accept, move on.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (out_valid === 1'b1) begin
      chk("out_has_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        chk("z1_stream", z1, q[0].z[0]);
        chk("z2_stream", z2, q[0].z[1]);
        chk("z3_stream", z3, q[0].z[2]);
        if (out_ready) begin
          void'(q.pop_front());
          out_seen++;
        end
      end
    end
    if (in_valid && in_ready === 1'b1) begin
      e = model(int'(y1), int'(y2), int'(y3), int'(b1), int'(b2), int'(b3),
                int'(shift), relu_en);
      q.push_back(e);
      exp_cnt = (exp_cnt + e.nsat > 65535) ? 65535 : exp_cnt + e.nsat;
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send_one();
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) cycle(acc);
    chk("accept_within_budget", int'(acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle(acc);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;
    int seen0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_z1", z1, 0);
    chk("reset_sat_count", sat_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // Pass-through with exact 2-cycle latency.
    set_vec(100, -50, 0, 0, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    cycle(acc);
    chk("pt_accept", int'(acc), 1);
    in_valid = 1'b0;
    chk("pt_lat1_out_valid", out_valid, 0);
    cycle(acc);
    chk("pt_lat2_out_valid", out_valid, 1);
    chk("pt_z1", z1, 100);
    chk("pt_z2", z2, -50);
    chk("pt_z3", z3, 0);
    drain();
    chk("pt_sat_count", sat_count, 0);

    // Saturation, then the same vector with ReLU.
    set_vec(300, -300, 127, 0, 0, 0, 0, 1'b0);
    send_one(); drain();
    chk("sat_z1", z1, 127);
    chk("sat_z2", z2, -128);
    chk("sat_z3", z3, 127);
    chk("sat_count_2", sat_count, 2);
    set_vec(300, -300, 127, 0, 0, 0, 0, 1'b1);
    send_one(); drain();
    chk("relu_z2", z2, 0);
    chk("relu_sat_count_3", sat_count, 3);

    // Rounding and bias without wrap.
    set_vec(255, -6, 32767, 0, 0, 32767, 2, 1'b0);
    send_one(); drain();
    chk("rnd_z1", z1, 64);
    chk("rnd_z2", z2, -1);
    chk("rnd_z3", z3, 127);
    chk("rnd_sat_count_4", sat_count, 4);

    // Largest shift with extreme sums.
    set_vec(-32768, 100, 32767, -32768, -100, 0, 15, 1'b0);
    send_one(); drain();
    chk("sh15_z1", z1, -2);
    chk("sh15_z2", z2, 0);
    chk("sh15_z3", z3, 1);
    chk("sh15_sat_count", sat_count, exp_cnt);

    // Backpressure: 5 vectors, out_ready low for the first 4 cycles.
    idx = 0;
    seen0 = out_seen;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = 1'b1;
      set_vec(10 * idx + 1, -(10 * idx + 2), 5 * idx, 0, 0, 0, 0, 1'b0);
      if (cyc == 2 || cyc == 3) begin
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_accepted_two", idx, 2);
        chk("bp_z1_hold", z1, 1);
        chk("bp_out_valid_hold", out_valid, 1);
      end
      cycle(acc);
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 5);
    drain();
    chk("bp_all_out", out_seen - seen0, 5);

    // Reset with both stages full.
    set_vec(500, 0, 0, 0, 0, 0, 0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    cycle(acc); cycle(acc);
    chk("rst_full_in_ready", in_ready, 0);
    chk("rst_full_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_z1", z1, 0);
    chk("rst_async_sat_count", sat_count, 0);
    q.delete();
    exp_cnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    set_vec(7, 8, 9, 0, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    cycle(acc);
    chk("rst_post_accept", int'(acc), 1);
    in_valid = 1'b0;
    chk("rst_post_lat1", out_valid, 0);
    cycle(acc);
    chk("rst_post_lat2", out_valid, 1);
    chk("rst_post_z1", z1, 7);
    drain();

    // Counter saturation at all-ones, then clear beats a same-cycle increment.
    set_vec(1000, -1000, 1000, 0, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 21850; i++) cycle(acc);
    drain();
    chk("cnt_sticky_ffff", sat_count, 16'hFFFF);
    chk("cnt_model", sat_count, exp_cnt);
    in_valid = 1'b1;
    cycle(acc);
    chk("clr_accept", int'(acc), 1);
    in_valid = 1'b0;
    clr_count = 1'b1;
    cycle(acc);
    clr_count = 1'b0;
    exp_cnt = 0;
    chk("clr_count_zero", sat_count, 0);
    drain();
    chk("clr_count_stays_zero", sat_count, 0);

    // Randomized stream with random stalls on both sides.
    in_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        if ($urandom_range(0, 1) == 1)
          set_vec(int'(16'($urandom)), int'(16'($urandom)), int'(16'($urandom)),
                  int'(16'($urandom)), int'(16'($urandom)), int'(16'($urandom)),
                  $urandom_range(0, 15), 1'($urandom));
        else
          set_vec($urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300,
                  $urandom_range(0, 600) - 300, $urandom_range(0, 64) - 32,
                  $urandom_range(0, 64) - 32, $urandom_range(0, 64) - 32,
                  $urandom_range(0, 3), 1'($urandom));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(acc);
      if (acc) in_valid = 1'b0;
    end
    drain();
    chk("rand_sat_count", sat_count, exp_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
